wb_grf: RTL

//  Write-back end of the M->W pipeline interface: consumes W-stage PC/Instr/ALUresult/RD,

---
 rtl/wb_grf_pkg.sv | 43 ++++
 rtl/wb_grf_if.sv | 28 ++
 rtl/wb_grf_decode.sv | 71 +++++++
 rtl/wb_grf.sv | 65 ++++++
 4 files changed

// File: rtl/wb_grf_pkg.sv
// Shared definitions for the write-back / register-file slice.
// Opcode and funct constants, the decode result record and the bypass read helper.
package wb_grf_pkg;

    localparam int         NREG     = 32;
    localparam logic [4:0] JAL_LINK = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Result of decoding the W-stage instruction.
    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        we;
    } wb_dec_t;

    // One D-stage read port: $0 reads zero, a matching in-flight write is
    // forwarded, otherwise the stored value is returned.
    function automatic logic [31:0] bypass_read(
        input logic [4:0]  addr,
        input wb_dec_t     dec,
        input logic [31:0] stored
    );
        logic [31:0] result;
        if (addr == 5'd0) begin
            result = 32'd0;
        end else if (dec.we && (dec.a3 == addr)) begin
            result = dec.wd;
        end else begin
            result = stored;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_grf_if.sv
// Bundle of W-stage inputs, D-stage read ports and hazard-unit outputs
// between the pipeline (master) and the write-back register file (slave).
interface wb_grf_if;

    logic [31:0] W_PC;
    logic [31:0] W_Instr;
    logic [31:0] W_ALUresult;
    logic [31:0] W_RD;
    logic [4:0]  D_A1;
    logic [4:0]  D_A2;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic        W_WE;
    logic [31:0] instret;

    modport master (
        output W_PC, W_Instr, W_ALUresult, W_RD, D_A1, D_A2,
        input  D_RD1, D_RD2, W_A3, W_WD, W_WE, instret
    );

    modport slave (
        input  W_PC, W_Instr, W_ALUresult, W_RD, D_A1, D_A2,
        output D_RD1, D_RD2, W_A3, W_WD, W_WE, instret
    );

endinterface

// File: rtl/wb_grf_decode.sv
// Combinational W-stage decode: picks destination register and write data.
// Unsupported or non-writing instructions (sw, beq, jr, bubble, unknown)
// produce A3=0, WD=0, WE=0; a write to $0 is never enabled.
import wb_grf_pkg::*;

module wb_decode (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd_data,
    output wb_dec_t     dec
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  a3_s;
    logic [31:0] wd_s;
    logic        writer_s;
    logic        unused_fields_s;

    assign op_s    = instr[31:26];
    assign funct_s = instr[5:0];

    // rs and shamt fields play no part in write-back.
    assign unused_fields_s = ^{instr[25:21], instr[10:6]};

    // Select destination and data source from opcode/funct.
    always_comb begin
        a3_s     = 5'd0;
        wd_s     = 32'd0;
        writer_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                if ((funct_s == FN_ADD) || (funct_s == FN_SUB)) begin
                    a3_s     = instr[15:11];
                    wd_s     = alu_result;
                    writer_s = 1'b1;
                end else begin
                    a3_s     = 5'd0;
                    wd_s     = 32'd0;
                    writer_s = 1'b0;
                end
            end
            OP_ORI, OP_LUI: begin
                a3_s     = instr[20:16];
                wd_s     = alu_result;
                writer_s = 1'b1;
            end
            OP_LW: begin
                a3_s     = instr[20:16];
                wd_s     = rd_data;
                writer_s = 1'b1;
            end
            OP_JAL: begin
                a3_s     = JAL_LINK;
                wd_s     = pc + 32'd8;
                writer_s = 1'b1;
            end
            default: begin
                a3_s     = 5'd0;
                wd_s     = 32'd0;
                writer_s = 1'b0;
            end
        endcase
    end

    assign dec.a3 = a3_s;
    assign dec.wd = wd_s;
    assign dec.we = writer_s && (a3_s != 5'd0);

endmodule

// File: rtl/wb_grf.sv
// Write-back stage with 32x32 general register file, same-cycle W->D bypass
// and retired-instruction counter. Optional macro GRF_TRACE_EN prints each
// committed register write.
import wb_grf_pkg::*;

module wb_grf (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);

    wb_dec_t     dec_s;
    logic [31:0] grf_r [NREG];
    logic [31:0] instret_r;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    wb_decode u_decode (
        .instr      (bus.W_Instr),
        .pc         (bus.W_PC),
        .alu_result (bus.W_ALUresult),
        .rd_data    (bus.W_RD),
        .dec        (dec_s)
    );

    // Commit the decoded write; reset clears every entry and beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                grf_r[i] <= 32'd0;
            end
        end else if (dec_s.we && (dec_s.a3 != 5'd0)) begin
            grf_r[dec_s.a3] <= dec_s.wd;
`ifdef GRF_TRACE_EN
            $display("%d@%h: $%d <= %h", $time, bus.W_PC, dec_s.a3, dec_s.wd);
`else
`endif
        end
    end

    // Count every non-bubble instruction leaving W; instruction in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_r <= 32'd0;
        end else if (bus.W_Instr != 32'd0) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Zero-latency D-stage reads with forwarding of the in-flight W write.
    always_comb begin
        rd1_s = bypass_read(bus.D_A1, dec_s, grf_r[bus.D_A1]);
        rd2_s = bypass_read(bus.D_A2, dec_s, grf_r[bus.D_A2]);
    end

    assign bus.D_RD1   = rd1_s;
    assign bus.D_RD2   = rd2_s;
    assign bus.W_A3    = dec_s.a3;
    assign bus.W_WD    = dec_s.wd;
    assign bus.W_WE    = dec_s.we;
    assign bus.instret = instret_r;

endmodule
